// File: rtl/mem_pkg.sv
// Shared definitions for the true dual-port memory: FSM states and read-mode selectors.
package mem_pkg;

  typedef enum logic {
    MEM_INIT,
    MEM_READY
  } mem_state_e;

  localparam int RD_FIRST = 0;
  localparam int WR_FIRST = 1;

endpackage

// File: rtl/mem_rdport.sv
// One read port: captured read word with write-first bypass mux and optional
// output register (MEM_TDP_OUTREG_EN).
module mem_rdport
  import mem_pkg::*;
#(
  parameter int DWIDTH = 16,
  parameter int RDMODE = RD_FIRST
) (
  input  logic                     clk,
  input  logic                     xrst,
  input  logic                     en,
  input  logic signed [DWIDTH-1:0] word,
  input  logic                     hit1,
  input  logic                     hit2,
  input  logic signed [DWIDTH-1:0] wdata1,
  input  logic signed [DWIDTH-1:0] wdata2,
  output logic signed [DWIDTH-1:0] rdata
);

  logic signed [DWIDTH-1:0] sel;
  logic signed [DWIDTH-1:0] data_q;

  // Port 1 write data wins when both ports hit the sampled address.
  always_comb begin
    sel = word;
    if (RDMODE == WR_FIRST) begin
      if (hit1)      sel = wdata1;
      else if (hit2) sel = wdata2;
    end
  end

  always_ff @(posedge clk) begin
    if (!xrst)   data_q <= '0;
    else if (en) data_q <= sel;
    else         data_q <= '0;
  end

`ifdef MEM_TDP_OUTREG_EN
  logic signed [DWIDTH-1:0] out_q;

  always_ff @(posedge clk) begin
    if (!xrst) out_q <= '0;
    else       out_q <= data_q;
  end

  assign rdata = out_q;
`else
  assign rdata = data_q;
`endif

endmodule

// File: rtl/mem_tdp.sv
// True dual-port RAM with zero-sweep init/clear FSM and write-collision flag.
// MEM_TDP_OUTREG_EN adds an output register per read port (2-cycle latency).
module mem_tdp
  import mem_pkg::*;
#(
  parameter int DWIDTH  = 16,
  parameter int MEMSIZE = 8,
  parameter int RDMODE  = RD_FIRST
) (
  input  logic                      clk,
  input  logic                      xrst,
  input  logic                      mem_clear,
  input  logic                      mem_we1,
  input  logic                      mem_we2,
  input  logic        [MEMSIZE-1:0] mem_addr1,
  input  logic        [MEMSIZE-1:0] mem_addr2,
  input  logic signed [DWIDTH-1:0]  mem_wdata1,
  input  logic signed [DWIDTH-1:0]  mem_wdata2,
  output logic signed [DWIDTH-1:0]  mem_rdata1,
  output logic signed [DWIDTH-1:0]  mem_rdata2,
  output logic                      mem_ready,
  output logic                      mem_collide
);

  localparam int WORDS = 2 ** MEMSIZE;

  logic signed [DWIDTH-1:0] mem [WORDS];

  mem_state_e         state;
  logic [MEMSIZE-1:0] sweep_cnt;
  logic               collide_q;
  logic               ready;
  logic               wr_en;
  logic               same_addr;
  logic               wr1;
  logic               wr2;

  assign ready     = (state == MEM_READY);
  assign wr_en     = ready && !mem_clear;
  assign same_addr = (mem_addr1 == mem_addr2);
  assign wr1       = wr_en && mem_we1;
  assign wr2       = wr_en && mem_we2 && !(mem_we1 && same_addr);

  always_ff @(posedge clk) begin
    if (!xrst) begin
      state     <= MEM_INIT;
      sweep_cnt <= '0;
      collide_q <= 1'b0;
    end else begin
      case (state)
        MEM_INIT: begin
          if (sweep_cnt == '1) state <= MEM_READY;
          sweep_cnt <= sweep_cnt + 1'b1;
        end
        MEM_READY: begin
          if (mem_clear) begin
            state     <= MEM_INIT;
            sweep_cnt <= '0;
          end
        end
        default: begin
          state     <= MEM_INIT;
          sweep_cnt <= '0;
        end
      endcase
      collide_q <= wr_en && mem_we1 && mem_we2 && same_addr;
    end
  end

  // Array has no reset; the sweep establishes the zero state instead.
  always_ff @(posedge clk) begin
    if (xrst) begin
      if (state == MEM_INIT) begin
        mem[sweep_cnt] <= '0;
      end else begin
        if (wr2) mem[mem_addr2] <= mem_wdata2;
        if (wr1) mem[mem_addr1] <= mem_wdata1;
      end
    end
  end

  mem_rdport #(
    .DWIDTH(DWIDTH),
    .RDMODE(RDMODE)
  ) u_rdport1 (
    .clk   (clk),
    .xrst  (xrst),
    .en    (ready),
    .word  (mem[mem_addr1]),
    .hit1  (wr1 && (mem_addr1 == mem_addr1)),
    .hit2  (wr2 && same_addr),
    .wdata1(mem_wdata1),
    .wdata2(mem_wdata2),
    .rdata (mem_rdata1)
  );

  mem_rdport #(
    .DWIDTH(DWIDTH),
    .RDMODE(RDMODE)
  ) u_rdport2 (
    .clk   (clk),
    .xrst  (xrst),
    .en    (ready),
    .word  (mem[mem_addr2]),
    .hit1  (wr1 && same_addr),
    .hit2  (wr2),
    .wdata1(mem_wdata1),
    .wdata2(mem_wdata2),
    .rdata (mem_rdata2)
  );

  assign mem_ready = ready;

`ifdef MEM_TDP_OUTREG_EN
  logic collide_d;

  always_ff @(posedge clk) begin
    if (!xrst) collide_d <= 1'b0;
    else       collide_d <= collide_q;
  end

  assign mem_collide = collide_d;
`else
  assign mem_collide = collide_q;
`endif

endmodule

// File: tb/tb_mem_tdp.sv
// Directed bench for mem_tdp: read-first and write-first instances driven in parallel.
module tb_mem_tdp;

`ifdef MEM_TDP_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic               clk = 1'b0;
  logic               xrst = 1'b0;
  logic               mem_clear = 1'b0;
  logic               we1 = 1'b0, we2 = 1'b0;
  logic [3:0]         a1 = '0, a2 = '0;
  logic signed [15:0] d1 = '0, d2 = '0;
  logic signed [15:0] rd1_rf, rd2_rf, rd1_wf, rd2_wf;
  logic               ready_rf, ready_wf, col_rf, col_wf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_tdp #(.DWIDTH(16), .MEMSIZE(4), .RDMODE(0)) u_rf (
    .clk(clk), .xrst(xrst), .mem_clear(mem_clear),
    .mem_we1(we1), .mem_we2(we2), .mem_addr1(a1), .mem_addr2(a2),
    .mem_wdata1(d1), .mem_wdata2(d2),
    .mem_rdata1(rd1_rf), .mem_rdata2(rd2_rf),
    .mem_ready(ready_rf), .mem_collide(col_rf)
  );

  mem_tdp #(.DWIDTH(16), .MEMSIZE(4), .RDMODE(1)) u_wf (
    .clk(clk), .xrst(xrst), .mem_clear(mem_clear),
    .mem_we1(we1), .mem_we2(we2), .mem_addr1(a1), .mem_addr2(a2),
    .mem_wdata1(d1), .mem_wdata2(d2),
    .mem_rdata1(rd1_wf), .mem_rdata2(rd2_wf),
    .mem_ready(ready_wf), .mem_collide(col_wf)
  );

  typedef struct {
    logic        we1, we2;
    logic [3:0]  a1, a2;
    logic [15:0] d1, d2;
    logic [15:0] rf1, rf2, wf1, wf2;
    logic        col;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One access cycle followed by idle cycles until its read data is due.
  task automatic access(input logic w1, input logic w2, input logic [3:0] x1, input logic [3:0] x2,
                        input logic [15:0] v1, input logic [15:0] v2);
    @(negedge clk);
    we1 = w1; we2 = w2; a1 = x1; a2 = x2; d1 = v1; d2 = v2;
    @(posedge clk);
    #1;
    we1 = 1'b0; we2 = 1'b0;
    for (int k = 1; k < LAT; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!ready_rf && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({name, "_cycles"}, 16'(n), 16'd16);
    chk({name, "_ready_wf"}, {15'd0, ready_wf}, 16'd1);
    chk({name, "_rd1_at_ready"}, rd1_rf, 16'h0000);
    chk({name, "_rd2_at_ready"}, rd2_wf, 16'h0000);
  endtask

  initial begin
    //         we1   we2   a1 a2 d1        d2        rf1       rf2       wf1       wf2      col
    vecs[0] = '{1'b1, 1'b0, 5, 0, 16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 16'h0000, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 5, 5, 16'h0000, 16'h0000, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 3, 3, 16'h00AA, 16'h00BB, 16'h0000, 16'h0000, 16'h00AA, 16'h00AA, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 3, 3, 16'h0000, 16'h0000, 16'h00AA, 16'h00AA, 16'h00AA, 16'h00AA, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 9, 7, 16'h0000, 16'h0011, 16'h0000, 16'h0000, 16'h0000, 16'h0011, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 7, 7, 16'h0022, 16'h0000, 16'h0011, 16'h0011, 16'h0022, 16'h0022, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 0, 15, 16'h7FFF, 16'h8000, 16'h0000, 16'h0000, 16'h7FFF, 16'h8000, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 0, 15, 16'h0000, 16'h0000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 1'b0};
    vecs[8] = '{1'b0, 1'b1, 2, 2, 16'h0000, 16'hBEEF, 16'h0000, 16'h0000, 16'hBEEF, 16'hBEEF, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {15'd0, ready_rf}, 16'd0);
    chk("rst_collide", {15'd0, col_rf}, 16'd0);
    chk("rst_rd1", rd1_rf, 16'h0000);
    chk("rst_rd2", rd2_wf, 16'h0000);
    @(negedge clk);
    xrst = 1'b1;
    wait_ready("init");

    // Table-driven accesses
    for (int i = 0; i < 9; i++) begin
      access(vecs[i].we1, vecs[i].we2, vecs[i].a1, vecs[i].a2, vecs[i].d1, vecs[i].d2);
      chk($sformatf("v%0d_rf_rd1", i), rd1_rf, vecs[i].rf1);
      chk($sformatf("v%0d_rf_rd2", i), rd2_rf, vecs[i].rf2);
      chk($sformatf("v%0d_wf_rd1", i), rd1_wf, vecs[i].wf1);
      chk($sformatf("v%0d_wf_rd2", i), rd2_wf, vecs[i].wf2);
      chk($sformatf("v%0d_rf_col", i), {15'd0, col_rf}, {15'd0, vecs[i].col});
      chk($sformatf("v%0d_wf_col", i), {15'd0, col_wf}, {15'd0, vecs[i].col});
    end

    // Fill, then clear; writes during the sweep must be dropped
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      we1 = 1'b1; a1 = 4'(i); d1 = 16'((i + 1) * 16'h0101);
    end
    access(1'b0, 1'b0, 4'd15, 4'd4, 16'h0, 16'h0);
    chk("fill_rd1", rd1_rf, 16'h1010);
    chk("fill_rd2", rd2_wf, 16'h0505);
    @(negedge clk);
    mem_clear = 1'b1;
    @(posedge clk);
    #1;
    mem_clear = 1'b0;
    we1 = 1'b1; we2 = 1'b1; a1 = 4'd4; a2 = 4'd9; d1 = 16'h5555; d2 = 16'h6666;
    chk("clear_ready_low", {15'd0, ready_rf}, 16'd0);
    wait_ready("clear");
    we1 = 1'b0; we2 = 1'b0;
    for (int i = 0; i < 16; i++) begin
      access(1'b0, 1'b0, 4'(i), 4'(15 - i), 16'h0, 16'h0);
      chk($sformatf("clr_rf_a%0d", i), rd1_rf, 16'h0000);
      chk($sformatf("clr_wf_a%0d", 15 - i), rd2_wf, 16'h0000);
    end

    // Reset in the middle of a sweep restarts it from address 0
    @(negedge clk);
    mem_clear = 1'b1;
    @(posedge clk);
    #1;
    mem_clear = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    xrst = 1'b0;
    we1 = 1'b1; a1 = 4'd6; d1 = 16'h7777;
    @(posedge clk);
    #1;
    chk("midrst_ready", {15'd0, ready_rf}, 16'd0);
    chk("midrst_rd1", rd1_wf, 16'h0000);
    chk("midrst_col", {15'd0, col_wf}, 16'd0);
    @(negedge clk);
    xrst = 1'b1;
    we1 = 1'b0;
    wait_ready("midrst");
    access(1'b0, 1'b0, 4'd6, 4'd0, 16'h0, 16'h0);
    chk("midrst_a6", rd1_rf, 16'h0000);
    chk("midrst_a0", rd2_rf, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_tdp.md
MEM_TDP -- requirements
Module: mem_tdp

Interface
REQ-001 SHALL have parameter DWIDTH, default 16: signed data width per word.
REQ-002 SHALL have parameter MEMSIZE, default 8: address width; depth WORDS = 2**MEMSIZE.
REQ-003 SHALL have parameter RDMODE, default 0: 0 = read-first, 1 = write-first for same-cycle read/write of one address.
REQ-004 SHALL have ports, one clock and synchronous active-low reset (clock and reset listed first):
- clk  in  1  sole clock, rising edge.
- xrst  in  1  synchronous active-low reset.
- mem_clear  in  1  request a zero-sweep of the whole array.
- mem_we1 / mem_we2  in  1  write enable, port 1 / port 2.
- mem_addr1 / mem_addr2  in  MEMSIZE  address, port 1 / port 2.
- mem_wdata1 / mem_wdata2  in  DWIDTH signed  write data.
- mem_rdata1 / mem_rdata2  out  DWIDTH signed  read data.
- mem_ready  out  1  high when the array is initialised and accepting accesses.
- mem_collide  out  1  one-cycle pulse on a same-address dual write.

Function
REQ-005 SHALL implement a two-state FSM: INIT (sweep) and READY.
REQ-006 In INIT, SHALL write zero to address sweep_cnt each cycle, counting 0 to WORDS-1, then enter READY on the following edge; the sweep lasts exactly WORDS cycles.
REQ-007 In INIT, SHALL hold mem_ready=0, ignore mem_we1/mem_we2, and drive both rdata ports to 0.
REQ-008 In READY, a mem_clear=1 sample SHALL return the FSM to INIT with sweep_cnt=0; mem_clear in INIT SHALL be ignored.
REQ-009 Both ports SHALL be fully read/write; a write sampled at edge N SHALL be visible to either port's read from edge N+1.
REQ-010 Read latency SHALL be 1 cycle: address sampled at edge N, data valid after edge N, held until the next sampled address.
REQ-011 Same port, same cycle read+write: RDMODE=0 SHALL return the old word; RDMODE=1 SHALL return mem_wdata of that port.
REQ-012 Cross-port, when port A writes and port B reads the same address in the same cycle, SHALL follow RDMODE identically.
REQ-013 When both ports write the same address in the same cycle, SHALL store port 1 data, drop port 2 data, and pulse mem_collide for exactly one cycle after that edge.
REQ-014 Writes to different addresses in the same cycle SHALL both commit.
REQ-015 In RDMODE=1, a same-address dual write SHALL return the port 1 data on both rdata ports.

Reset
REQ-016 xrst=0 at an edge SHALL force state INIT, sweep_cnt=0, mem_ready=0, mem_collide=0, and both rdata outputs (and output registers) to 0.
REQ-017 Reset asserted mid-sweep or mid-access SHALL restart the sweep from address 0; no partial write SHALL commit on the reset edge.
REQ-018 Array contents SHALL be guaranteed zero only after the first sweep completes (mem_ready=1).

Configuration
REQ-019 Macro MEM_TDP_OUTREG_EN defined: SHALL add one output register per read port, giving 2-cycle read latency; mem_collide SHALL be delayed one extra cycle to stay aligned with rdata.
REQ-020 Macro undefined: SHALL keep 1-cycle latency per REQ-010; all other behaviour SHALL be identical.

Structure
REQ-021 Shared package mem_pkg SHALL hold the FSM state enum (MEM_INIT, MEM_READY) and RDMODE constants (RD_FIRST=0, WR_FIRST=1).
REQ-022 Single sub-module mem_rdport (address register, RDMODE bypass mux, optional output register) SHALL be instantiated once per port.

Verification
REQ-023 Reset release with MEMSIZE=4 -> mem_ready rises exactly 16 cycles later; a read of any address then returns 0.
REQ-024 Port1 writes 0x1234 at addr 5, next cycle port2 reads addr 5 -> rdata2=0x1234 one cycle later (two cycles with MEM_TDP_OUTREG_EN).
REQ-025 Both ports write addr 3 (0x00AA, 0x00BB) -> mem_collide pulses once; subsequent read of addr 3 = 0x00AA.
REQ-026 Addr 7 holds 0x0011; port1 writes 0x0022 to 7 while port2 reads 7 -> rdata2=0x0011 (RDMODE=0) or 0x0022 (RDMODE=1).
REQ-027 Fill addr 0..15 with nonzero data, pulse mem_clear -> mem_ready low 16 cycles, writes during sweep are ignored, all reads return 0 afterwards.
REQ-028 xrst asserted at sweep address 6 -> sweep restarts at 0; mem_ready rises exactly 16 cycles after xrst deasserts.
